spi_shift_master: RTL and testbench
===================================

Name: spi_shift_master

Overview:
- Serial engine directly downstream of the Wishbone SPI control slave.
- Consumes its 32-bit transmit word, start bit and 2-bit device select, and performs one full-duplex SPI mode-0 transfer, MSB first.
- Returns the received word and a done flag, which the slave exposes to PCI software.
- Drives the board-level SCLK/MOSI/CS_N pins and samples MISO.

Parameters:
CLK_DIV, 4, clk_i cycles per SCLK half-period; legal range 1..255.
DATA_W, 32, bits per transfer; must match the slave's data registers.
NUM_CS, 4, chip-select lines; equals 2**width(spi_sel_i).

Ports:
clk_i  in  1  system clock
reset_n_i  in  1  synchronous reset, active-low
spi_dat_i  in  DATA_W  word to transmit (slave SPI_O)
spi_start_i  in  1  start request level (slave SPI_STAR_O)
spi_sel_i  in  2  target device index (slave SPI_SEL_O)
spi_dat_o  out  DATA_W  last received word (slave SPI_I)
spi_done_o  out  1  transfer-complete flag (slave SPI_DONE_I)
sclk_o  out  1  SPI clock, idle low
mosi_o  out  1  serial data out
miso_i  in  1  serial data in; board-synchronous to sclk_o, no synchroniser
cs_n_o  out  NUM_CS  active-low chip selects, one-hot-low when active

Behaviour:
- One clock (clk_i). Reset is synchronous, active-low (reset_n_i).
- Reset values (reset_n_i low at a clk_i edge):
  - state IDLE; sclk_o=0; mosi_o=0; cs_n_o all 1
  - spi_done_o=0; spi_dat_o=0; start-edge history=0
- Start is rising-edge triggered. A registered copy of spi_start_i is compared each cycle, because software leaves the start bit at 1 after writing it.
- Edge detected in IDLE (edge cycle E0):
  - latch spi_dat_i into tx shift register and spi_sel_i into sel register
  - clear spi_done_o
  - drive cs_n_o[sel]=0 and mosi_o=tx[DATA_W-1]
  - enter SETUP
- An edge arriving while not IDLE is discarded, not queued. A level held high never retriggers.
- States:
  - IDLE: outputs at rest values; spi_done_o and spi_dat_o hold.
  - SETUP: CLK_DIV cycles, then SHIFT with sclk_o driven 1 (first rising edge).
  - SHIFT: 2*DATA_W half-periods of CLK_DIV cycles each. On each 0->1 sclk transition, sample miso_i into the rx shift register LSB (shift left). On each 1->0 transition except the last, shift tx left and drive the next bit on mosi_o. After the final half-period (sclk_o=0), go to HOLD.
  - HOLD: CLK_DIV cycles with CS still low, then:
    - cs_n_o all 1, mosi_o=0
    - spi_dat_o <= rx register (first received bit in MSB)
    - spi_done_o=1
    - back to IDLE
- Latency: spi_done_o rises exactly (2*DATA_W+2)*CLK_DIV cycles after E0, i.e. 132 cycles for CLK_DIV=2, DATA_W=32.
- spi_done_o stays 1 until the next accepted start edge.
- spi_dat_o changes only at transfer completion.
- spi_dat_i/spi_sel_i changes after E0 have no effect on the current transfer.
- Exactly one cs_n_o bit is low during SETUP, SHIFT and HOLD; none otherwise.
- The half-period counter wraps to 0 at CLK_DIV-1 and restarts at every state entry.
- reset_n_i low mid-transfer aborts immediately to reset values. No completion is reported, and spi_dat_o is cleared.
- CLK_DIV=1 is legal: SCLK = clk_i/2, with no glitch on sclk_o (sclk_o is a register output).

Decomposition:
- Shared package:
  - state encoding constants (IDLE, SETUP, SHIFT, HOLD; 2 bits)
  - SPI_DATA_W=32
  - SPI_NUM_CS=4
  - SPI_MODE0 timing constants
- One natural sub-module: spi_half_period_timer. It is a CLK_DIV counter with a restart input and a one-cycle tick output at terminal count, used by every state.
- Bit counter (6 bits for 64 half-periods) and shift registers stay in the top.

Test Plan:
- Loopback (miso_i tied to mosi_o), CLK_DIV=2, spi_dat_i=32'hA5C3_0F81, sel=2, pulse start high -> cs_n_o=4'b1011 during the transfer; 32 sclk rising edges; spi_done_o rises 132 cycles after E0; spi_dat_o=32'hA5C3_0F81.
- MISO model driving 32'h1234_5678 MSB-first on sclk falling edges, mosi checked against 32'hDEAD_BEEF -> spi_dat_o=32'h1234_5678; every mosi bit stable across each sclk rising edge.
- Hold spi_start_i high through completion, then toggle it 1->0->1 mid-transfer -> only one transfer occurs; a fresh 0->1 after done starts a second transfer and clears spi_done_o at its E0.
- Change spi_dat_i to 0 and sel to 0 one cycle after E0 -> original word transmitted on the original CS line.
- Assert reset_n_i=0 at sclk edge 10 -> next cycle cs_n_o=4'hF, sclk_o=0, spi_done_o=0, spi_dat_o=0; a subsequent start completes normally.
- CLK_DIV=1 loopback of 32'hFFFF_0000 -> done 66 cycles after E0; sclk_o period 2 cycles; data matches.

Source files
------------

// File: rtl/spi_shift_master_pkg.sv
// spi_shift_master_pkg: shared state encoding and SPI mode-0 constants for the shift master
package spi_shift_master_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, SETUP = 2'd1, SHIFT = 2'd2, HOLD = 2'd3} state_t;
  localparam int SPI_DATA_W = 32;
  localparam int SPI_NUM_CS = 4;
  localparam logic SPI_MODE0_CPOL = 1'b0;
  localparam logic SPI_MODE0_CPHA = 1'b0;
  function automatic int spi_latency(input int clk_div, input int data_w);
    return (2 * data_w + 2) * clk_div;
  endfunction
endpackage

// File: rtl/spi_half_period_timer.sv
// spi_half_period_timer: CLK_DIV-cycle counter with restart and a one-cycle tick at terminal count
module spi_half_period_timer
  import spi_shift_master_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic clk_i,
  input  logic reset_n_i,
  input  logic restart,
  output logic tick
);
  logic [7:0] cnt;
  assign tick = cnt == 8'(CLK_DIV - 1);
  always_ff @(posedge clk_i)
    if (!reset_n_i || restart || tick) cnt <= '0;
    else cnt <= cnt + 1'b1;
endmodule

// File: rtl/spi_shift_master.sv
// spi_shift_master: single full-duplex SPI mode-0 transfer engine, MSB first, rising-edge start
module spi_shift_master
  import spi_shift_master_pkg::*;
#(
  parameter int CLK_DIV = 4,
  parameter int DATA_W  = SPI_DATA_W,
  parameter int NUM_CS  = SPI_NUM_CS
) (
  input  logic              clk_i,
  input  logic              reset_n_i,
  input  logic [DATA_W-1:0] spi_dat_i,
  input  logic              spi_start_i,
  input  logic [1:0]        spi_sel_i,
  output logic [DATA_W-1:0] spi_dat_o,
  output logic              spi_done_o,
  output logic              sclk_o,
  output logic              mosi_o,
  input  logic              miso_i,
  output logic [NUM_CS-1:0] cs_n_o
);
  localparam int HW = $clog2(2 * DATA_W);
  localparam logic [HW-1:0] LAST = HW'(2 * DATA_W - 1);
  localparam logic [HW-1:0] LAST_FALL = HW'(2 * DATA_W - 2);
  state_t state, state_next;
  logic start_q, start_edge, restart, tick;
  logic [DATA_W-1:0] tx, rx;
  logic [1:0] sel;
  logic [HW-1:0] hcnt;
  assign start_edge = spi_start_i && !start_q;
  assign cs_n_o = (state == IDLE) ? '1 : ~(NUM_CS'(1) << sel);
  spi_half_period_timer #(.CLK_DIV(CLK_DIV)) u_timer (
    .clk_i(clk_i),
    .reset_n_i(reset_n_i),
    .restart(restart),
    .tick(tick)
  );
  always_ff @(posedge clk_i)
    if (!reset_n_i) state <= IDLE;
    else state <= state_next;
  always_comb begin
    state_next = (state == IDLE && start_edge) ? SETUP :
                 (state == SETUP && tick) ? SHIFT :
                 (state == SHIFT && tick && !sclk_o && hcnt == LAST) ? HOLD :
                 (state == HOLD && tick) ? IDLE : state;
    restart = state_next != state;
  end
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      start_q    <= 1'b0;
      sclk_o     <= SPI_MODE0_CPOL;
      mosi_o     <= 1'b0;
      spi_done_o <= 1'b0;
      spi_dat_o  <= '0;
      tx         <= '0;
      rx         <= '0;
      sel        <= '0;
      hcnt       <= '0;
    end else begin
      start_q <= spi_start_i;
      if (state == IDLE && start_edge) begin
        tx         <= spi_dat_i;
        sel        <= spi_sel_i;
        mosi_o     <= spi_dat_i[DATA_W-1];
        spi_done_o <= 1'b0;
      end
      if (state == SETUP && tick) begin
        sclk_o <= 1'b1;
        rx     <= {rx[DATA_W-2:0], miso_i};
        hcnt   <= '0;
      end
      // even half-periods end on a falling edge, odd ones on a rising edge
      if (state == SHIFT && tick) begin
        hcnt <= hcnt + 1'b1;
        if (sclk_o) begin
          sclk_o <= 1'b0;
          if (hcnt != LAST_FALL) begin
            tx     <= {tx[DATA_W-2:0], 1'b0};
            mosi_o <= tx[DATA_W-2];
          end
        end else if (hcnt != LAST) begin
          sclk_o <= 1'b1;
          rx     <= {rx[DATA_W-2:0], miso_i};
        end
      end
      if (state == HOLD && tick) begin
        mosi_o     <= 1'b0;
        spi_dat_o  <= rx;
        spi_done_o <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_spi_shift_master.sv
// tb_spi_shift_master: scoreboard bench for spi_shift_master at CLK_DIV=2 and CLK_DIV=1
module tb_spi_shift_master;
  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;
  logic [31:0] dat2 = '0, dat_o2, slave_reg = '0;
  logic [1:0] sel2 = '0;
  logic start2 = 1'b0, done2, sclk2, mosi2, miso2, loop_m = 1'b1;
  logic [3:0] cs2;
  logic [31:0] dat1 = '0, dat_o1;
  logic start1 = 1'b0, done1, sclk1, mosi1;
  logic [3:0] cs1;
  assign miso2 = loop_m ? mosi2 : slave_reg[31];
  spi_shift_master #(.CLK_DIV(2)) u2 (
    .clk_i(clk), .reset_n_i(rst_n), .spi_dat_i(dat2), .spi_start_i(start2), .spi_sel_i(sel2),
    .spi_dat_o(dat_o2), .spi_done_o(done2), .sclk_o(sclk2), .mosi_o(mosi2), .miso_i(miso2), .cs_n_o(cs2)
  );
  spi_shift_master #(.CLK_DIV(1)) u1 (
    .clk_i(clk), .reset_n_i(rst_n), .spi_dat_i(dat1), .spi_start_i(start1), .spi_sel_i(2'd1),
    .spi_dat_o(dat_o1), .spi_done_o(done1), .sclk_o(sclk1), .mosi_o(mosi1), .miso_i(mosi1), .cs_n_o(cs1)
  );
  int checks = 0, errors = 0;
  logic [31:0] sb[$];
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  // slave model shifts its next bit out on each sclk falling edge
  always @(negedge sclk2) slave_reg = slave_reg << 1;
  int rises2 = 0, unstable2 = 0, rises1 = 0, gap_bad1 = 0, cyc = 0, last_rise1 = 0;
  logic sclk2_p = 1'b0, mosi2_p = 1'b0, sclk1_p = 1'b0;
  logic [31:0] mosi_cap = '0;
  always @(posedge clk) cyc++;
  always @(negedge clk) begin
    if (sclk2 && !sclk2_p) begin
      rises2++;
      mosi_cap = {mosi_cap[30:0], mosi2};
      if (mosi2 !== mosi2_p) unstable2++;
    end
    if (sclk1 && !sclk1_p) begin
      rises1++;
      if (last_rise1 != 0 && cyc - last_rise1 != 2) gap_bad1++;
      last_rise1 = cyc;
    end
    sclk2_p = sclk2;
    mosi2_p = mosi2;
    sclk1_p = sclk1;
  end
  task automatic pop_chk(input string tag, input logic [31:0] got);
    if (sb.size() == 0) chk({tag, "_sb_empty"}, 32'd0, 32'd1);
    else chk(tag, got, sb.pop_front());
  endtask
  // mode 0: pulse start; 1: hold start high with a mid-transfer re-toggle; 2: change inputs after E0
  task automatic xfer(input logic [31:0] d, input logic [1:0] s, input logic loop, input logic [31:0] pat, input int mode);
    int n = 0, r0, u0, cs_bad = 0;
    logic [3:0] cs_exp = ~(4'b0001 << s);
    dat2 = d; sel2 = s; loop_m = loop; slave_reg = pat; start2 = 1'b1;
    sb.push_back(loop ? d : pat);
    r0 = rises2; u0 = unstable2;
    @(posedge clk); #1;
    chk("cs_at_e0", {28'd0, cs2}, {28'd0, cs_exp});
    chk("done_clr_e0", {31'd0, done2}, 32'd0);
    if (mode != 1) start2 = 1'b0;
    while (n < 400) begin
      @(posedge clk); #1;
      n++;
      if (mode == 2 && n == 1) begin dat2 = '0; sel2 = '0; end
      if (mode == 1 && n == 40) start2 = 1'b0;
      if (mode == 1 && n == 41) start2 = 1'b1;
      if (done2) break;
      if (cs2 !== cs_exp) cs_bad++;
    end
    chk("latency", n, 132);
    chk("cs_during", cs_bad, 0);
    chk("cs_after", {28'd0, cs2}, 32'hF);
    chk("sclk_rises", rises2 - r0, 32);
    chk("mosi_stream", mosi_cap, d);
    chk("mosi_stable", unstable2 - u0, 0);
    pop_chk("rx_word", dat_o2);
  endtask
  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cs", {28'd0, cs2}, 32'hF);
    chk("rst_sclk", {31'd0, sclk2}, 32'd0);
    chk("rst_mosi", {31'd0, mosi2}, 32'd0);
    chk("rst_done", {31'd0, done2}, 32'd0);
    chk("rst_dat", dat_o2, 32'd0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    xfer(32'hA5C3_0F81, 2'd2, 1'b1, 32'h0, 0);
    xfer(32'hDEAD_BEEF, 2'd0, 1'b0, 32'h1234_5678, 0);
    xfer(32'h0F0F_1234, 2'd1, 1'b1, 32'h0, 1);
    repeat (20) @(posedge clk);
    #1;
    chk("no_retrigger_cs", {28'd0, cs2}, 32'hF);
    chk("no_retrigger_done", {31'd0, done2}, 32'd1);
    start2 = 1'b0;
    @(posedge clk); #1;
    xfer(32'h8000_0001, 2'd3, 1'b1, 32'h0, 0);
    xfer(32'h5A5A_C3C3, 2'd3, 1'b1, 32'h0, 2);
    begin
      int n = 0, r0 = rises2;
      dat2 = 32'h1357_9BDF; sel2 = 2'd1; loop_m = 1'b1; start2 = 1'b1;
      @(posedge clk); #1;
      start2 = 1'b0;
      while (n < 1000 && rises2 - r0 < 10) begin @(posedge clk); #1; n++; end
      chk("reach_edge10", {31'd0, rises2 - r0 >= 10}, 32'd1);
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      chk("abort_cs", {28'd0, cs2}, 32'hF);
      chk("abort_sclk", {31'd0, sclk2}, 32'd0);
      chk("abort_done", {31'd0, done2}, 32'd0);
      chk("abort_dat", dat_o2, 32'd0);
      n = 0;
      while (n < 300 && !done2) begin @(posedge clk); #1; n++; end
      chk("abort_no_done", {31'd0, done2}, 32'd0);
    end
    xfer(32'h2468_ACE0, 2'd0, 1'b1, 32'h0, 0);
    begin
      int n = 0;
      dat1 = 32'hFFFF_0000; start1 = 1'b1;
      sb.push_back(32'hFFFF_0000);
      @(posedge clk); #1;
      start1 = 1'b0;
      chk("div1_cs", {28'd0, cs1}, 32'hD);
      while (n < 200) begin @(posedge clk); #1; n++; if (done1) break; end
      chk("div1_latency", n, 66);
      chk("div1_rises", rises1, 32);
      chk("div1_period", gap_bad1, 0);
      pop_chk("div1_rx_word", dat_o1);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
